// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: shares the single write port between the
// writeback stage and the multiply/divide unit and tracks in-flight MDU targets.
module rf_wport_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rw,
  input  logic [5:0]  wb_op,
  input  logic [31:0] wb_data,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rw,
  input  logic        id_we,
  output logic        id_stall,
  output logic        pipe_hold,
  output logic        rf_we,
  output logic [4:0]  rf_rw,
  output logic [5:0]  rf_op,
  output logic [31:0] rf_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic [31:0]    sb;
  logic [31:0]    sb_next;
  logic           wb_grant;
  logic           mdu_grant;

  // In FORCE the pipeline is frozen, so the MDU owns the port regardless of wb_we.
  assign wb_grant  = wb_we && (state != ST_FORCE);
  assign mdu_grant = mdu_valid && (!wb_we || (state == ST_FORCE));
  assign mdu_ready = mdu_grant;

  assign id_stall = (sb[id_rs] && (id_rs != 5'd0)) ||
                    (sb[id_rt] && (id_rt != 5'd0)) ||
                    (id_we && sb[id_rw] && (id_rw != 5'd0));

  // A new issue to a register overrides a same-cycle completion to it.
  always_comb begin
    sb_next = sb;
    if (mdu_grant && (mdu_rd != 5'd0))
      sb_next[mdu_rd] = 1'b0;
    if (mdu_issue && (mdu_issue_rd != 5'd0))
      sb_next[mdu_issue_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      sb <= '0;
    else
      sb <= sb_next;
  end

  // Starvation FSM: after MAX_WAIT+1 refusals the pipeline is held for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      pipe_hold <= 1'b0;
    end else begin
      pipe_hold <= 1'b0;
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (mdu_valid && !mdu_grant) begin
            state    <= ST_WAIT;
            wait_cnt <= CW'(1);
          end
        end
        ST_WAIT: begin
          if (mdu_grant || !mdu_valid) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (wait_cnt == CW'(MAX_WAIT)) begin
            state     <= ST_FORCE;
            wait_cnt  <= '0;
            pipe_hold <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_FORCE: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Writes to r0 still update the captured fields but never assert rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_rw   <= '0;
      rf_op   <= '0;
      rf_data <= '0;
    end else if (wb_grant) begin
      rf_we   <= (wb_rw != 5'd0);
      rf_rw   <= wb_rw;
      rf_op   <= wb_op;
      rf_data <= wb_data;
    end else if (mdu_grant) begin
      rf_we   <= (mdu_rd != 5'd0);
      rf_rw   <= mdu_rd;
      rf_op   <= 6'b000000;
      rf_data <= mdu_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: expected register-file writes are
// queued as stimulus is driven and compared when the registered outputs appear.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [5:0]  wb_op;
  logic [31:0] wb_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rw;
  logic        id_we;
  logic        id_stall;
  logic        pipe_hold;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [5:0]  rf_op;
  logic [31:0] rf_data;

  typedef struct {
    logic        we;
    logic        chk;
    logic [4:0]  rw;
    logic [5:0]  op;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.MAX_WAIT(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_op(wb_op), .wb_data(wb_data),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rw(id_rw), .id_we(id_we),
    .id_stall(id_stall), .pipe_hold(pipe_hold),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_op(rf_op), .rf_data(rf_data)
  );

  // Scoreboard consumer: one queued expectation per clock edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ((rf_we !== e.we) ||
          (e.chk && ((rf_rw !== e.rw) || (rf_op !== e.op) || (rf_data !== e.data)))) begin
        n_fail++;
        $display("[TB] FAIL rf_out: got we=%b rw=%0d op=%b data=%h, expected we=%b rw=%0d op=%b data=%h (fields checked=%b)",
                 rf_we, rf_rw, rf_op, rf_data, e.we, e.rw, e.op, e.data, e.chk);
      end
    end
  end

  // Queue the expected rf_* for the coming edge, then advance past it.
  task automatic tick(input logic we, input logic chk, input logic [4:0] rw,
                      input logic [5:0] op, input logic [31:0] data);
    exp_t e;
    e.we = we; e.chk = chk; e.rw = rw; e.op = op; e.data = data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rw = 0; wb_op = 0; wb_data = 0;
    mdu_issue = 0; mdu_issue_rd = 0; mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    id_rs = 0; id_rt = 0; id_rw = 0; id_we = 0;
  endtask

  task automatic test_reset();
    logic [4:0] probes [8];
    probes = '{5'd1, 5'd4, 5'd7, 5'd9, 5'd16, 5'd21, 5'd30, 5'd31};
    idle_inputs();
    rst = 1;
    wb_we = 1; wb_rw = 5'd3; wb_op = 6'b100011; wb_data = 32'hDEADBEEF;
    mdu_valid = 1; mdu_rd = 5'd4; mdu_data = 32'h11111111;
    mdu_issue = 1; mdu_issue_rd = 5'd4;
    tick(0, 1, 5'd0, 6'd0, 32'd0);
    tick(0, 1, 5'd0, 6'd0, 32'd0);
    n_checks++;
    if (pipe_hold !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_pipe_hold: got %b, expected 0", pipe_hold);
    end
    n_checks++;
    if (mdu_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_mdu_ready: got %b, expected 0", mdu_ready);
    end
    rst = 0;
    idle_inputs();
    id_we = 1;
    foreach (probes[i]) begin
      id_rs = probes[i]; id_rt = probes[i]; id_rw = probes[i];
      #1;
      n_checks++;
      if (id_stall !== 1'b0) begin
        n_fail++; $display("[TB] FAIL reset_sb_r%0d: id_stall got %b, expected 0", probes[i], id_stall);
      end
    end
    idle_inputs();
    tick(0, 1, 5'd0, 6'd0, 32'd0);
  endtask

  task automatic test_wb_only();
    wb_we = 1; wb_rw = 5'd8; wb_op = 6'b100000; wb_data = 32'h000000A5;
    tick(1, 1, 5'd8, 6'b100000, 32'h000000A5);
    wb_we = 0;
    tick(0, 1, 5'd8, 6'b100000, 32'h000000A5);
    wb_we = 1; wb_rw = 5'd31; wb_op = 6'b100100; wb_data = 32'hFFFFFF80;
    tick(1, 1, 5'd31, 6'b100100, 32'hFFFFFF80);
    wb_rw = 5'd0; wb_op = 6'b100011; wb_data = 32'h0BADF00D;
    tick(0, 0, 5'd0, 6'd0, 32'd0);
    idle_inputs();
    tick(0, 0, 5'd0, 6'd0, 32'd0);
  endtask

  task automatic test_mdu_hazard();
    mdu_issue = 1; mdu_issue_rd = 5'd9;
    tick(0, 0, 5'd0, 6'd0, 32'd0);
    mdu_issue = 0;
    id_rs = 5'd9; #1;
    n_checks++;
    if (id_stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hazard_rs: id_stall got %b, expected 1", id_stall);
    end
    id_rs = 5'd0; id_rt = 5'd9; #1;
    n_checks++;
    if (id_stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hazard_rt: id_stall got %b, expected 1", id_stall);
    end
    id_rt = 5'd0; id_rs = 5'd9;
    mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h12345678; #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hazard_ready: got %b, expected 1", mdu_ready);
    end
    n_checks++;
    if (id_stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL hazard_same_cycle_stall: got %b, expected 1", id_stall);
    end
    tick(1, 1, 5'd9, 6'b000000, 32'h12345678);
    mdu_valid = 0; #1;
    n_checks++;
    if (id_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL hazard_release: id_stall got %b, expected 0", id_stall);
    end
    idle_inputs();
    tick(0, 1, 5'd9, 6'b000000, 32'h12345678);
  endtask

  // Two refusals then a free cycle: the grant must return the FSM to IDLE.
  task automatic test_wait_release();
    mdu_valid = 1; mdu_rd = 5'd12; mdu_data = 32'h0000C0DE;
    for (int i = 0; i < 2; i++) begin
      wb_we = 1; wb_rw = 5'(20 + i); wb_op = 6'b100011; wb_data = 32'(i + 100);
      #1;
      n_checks++;
      if (mdu_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL wait_refuse_%0d: mdu_ready got %b, expected 0", i, mdu_ready);
      end
      tick(1, 1, 5'(20 + i), 6'b100011, 32'(i + 100));
    end
    wb_we = 0; #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL wait_grant: mdu_ready got %b, expected 1", mdu_ready);
    end
    tick(1, 1, 5'd12, 6'b000000, 32'h0000C0DE);
    idle_inputs();
    tick(0, 1, 5'd12, 6'b000000, 32'h0000C0DE);
  endtask

  task automatic starve(input logic [4:0] rd, input logic [31:0] data);
    mdu_valid = 1; mdu_rd = rd; mdu_data = data;
    for (int i = 0; i < 5; i++) begin
      wb_we = 1; wb_rw = 5'(16 + i); wb_op = 6'b100011; wb_data = 32'hA000_0000 + 32'(i);
      #1;
      n_checks++;
      if ((mdu_ready !== 1'b0) || (pipe_hold !== 1'b0)) begin
        n_fail++;
        $display("[TB] FAIL starve_refuse_%0d: mdu_ready=%b pipe_hold=%b, expected 0 0", i, mdu_ready, pipe_hold);
      end
      tick(1, 1, 5'(16 + i), 6'b100011, 32'hA000_0000 + 32'(i));
    end
  endtask

  task automatic test_starvation();
    starve(5'd11, 32'hCAFEF00D);
    wb_rw = 5'd25; wb_data = 32'h5555AAAA; #1;
    n_checks++;
    if ((pipe_hold !== 1'b1) || (mdu_ready !== 1'b1)) begin
      n_fail++;
      $display("[TB] FAIL starve_force: pipe_hold=%b mdu_ready=%b, expected 1 1", pipe_hold, mdu_ready);
    end
    tick(1, 1, 5'd11, 6'b000000, 32'hCAFEF00D);
    idle_inputs(); #1;
    n_checks++;
    if (pipe_hold !== 1'b0) begin
      n_fail++; $display("[TB] FAIL starve_release: pipe_hold got %b, expected 0", pipe_hold);
    end
    tick(0, 1, 5'd11, 6'b000000, 32'hCAFEF00D);
  endtask

  task automatic test_force_drop();
    starve(5'd13, 32'h0F0F0F0F);
    mdu_valid = 0;
    wb_rw = 5'd26; wb_data = 32'h77777777; #1;
    n_checks++;
    if ((pipe_hold !== 1'b1) || (mdu_ready !== 1'b0)) begin
      n_fail++;
      $display("[TB] FAIL force_drop: pipe_hold=%b mdu_ready=%b, expected 1 0", pipe_hold, mdu_ready);
    end
    tick(0, 1, 5'd20, 6'b100011, 32'hA000_0004);
    idle_inputs(); #1;
    n_checks++;
    if (pipe_hold !== 1'b0) begin
      n_fail++; $display("[TB] FAIL force_drop_release: pipe_hold got %b, expected 0", pipe_hold);
    end
    tick(0, 1, 5'd20, 6'b100011, 32'hA000_0004);
  endtask

  task automatic test_r0_waw();
    mdu_valid = 1; mdu_rd = 5'd0; mdu_data = 32'h99999999; #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL r0_ready: got %b, expected 1", mdu_ready);
    end
    tick(0, 0, 5'd0, 6'd0, 32'd0);
    mdu_valid = 0;
    mdu_issue = 1; mdu_issue_rd = 5'd5;
    tick(0, 0, 5'd0, 6'd0, 32'd0);
    mdu_issue = 0;
    id_we = 0; id_rw = 5'd5; #1;
    n_checks++;
    if (id_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL waw_no_we: id_stall got %b, expected 0", id_stall);
    end
    id_we = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (id_stall !== 1'b1) begin
        n_fail++; $display("[TB] FAIL waw_stall_%0d: id_stall got %b, expected 1", i, id_stall);
      end
      tick(0, 0, 5'd0, 6'd0, 32'd0);
    end
    mdu_valid = 1; mdu_rd = 5'd5; mdu_data = 32'h00050005;
    tick(1, 1, 5'd5, 6'b000000, 32'h00050005);
    mdu_valid = 0; #1;
    n_checks++;
    if (id_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL waw_release: id_stall got %b, expected 0", id_stall);
    end
    idle_inputs();
    tick(0, 1, 5'd5, 6'b000000, 32'h00050005);
  endtask

  task automatic test_collision();
    mdu_issue = 1; mdu_issue_rd = 5'd7;
    tick(0, 0, 5'd0, 6'd0, 32'd0);
    mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h70707070; #1;
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL collide_ready: got %b, expected 1", mdu_ready);
    end
    tick(1, 1, 5'd7, 6'b000000, 32'h70707070);
    mdu_valid = 0; mdu_issue = 0;
    id_rs = 5'd7; #1;
    n_checks++;
    if (id_stall !== 1'b1) begin
      n_fail++; $display("[TB] FAIL collide_set_wins: id_stall got %b, expected 1", id_stall);
    end
    mdu_issue = 1; mdu_issue_rd = 5'd7;
    tick(0, 1, 5'd7, 6'b000000, 32'h70707070);
    mdu_issue = 0;
    mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h07070707;
    tick(1, 1, 5'd7, 6'b000000, 32'h07070707);
    mdu_valid = 0; #1;
    n_checks++;
    if (id_stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL collide_final_clear: id_stall got %b, expected 0", id_stall);
    end
    idle_inputs();
    tick(0, 1, 5'd7, 6'b000000, 32'h07070707);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_wb_only();
    test_mdu_hazard();
    test_wait_release();
    test_starvation();
    test_force_drop();
    test_r0_waw();
    test_collision();
    #5;
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
